// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state, hit and winner encodings for the pong game controller
package pong_pkg;

    typedef enum logic [1:0] {
        S_NEWGAME = 2'd0,
        S_PLAY    = 2'd1,
        S_NEWBALL = 2'd2,
        S_OVER    = 2'd3
    } state_t;

    localparam logic [1:0] HIT_RIGHT = 2'b10;
    localparam logic [1:0] HIT_LEFT  = 2'b01;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_P1    = 2'b01;
    localparam logic [1:0] WIN_P2    = 2'b10;

endpackage

// File: rtl/bcd2_counter.sv
// rtl/bcd2_counter.sv - two-digit BCD score counter with binary shadow count
module bcd2_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clr,
    input  logic       i_inc,
    output logic [7:0] o_bcd,
    output logic [6:0] o_bin
);

    logic [3:0] r_tens;
    logic [3:0] r_ones;
    logic [6:0] r_bin;

    // BCD digits and binary shadow advance together; clear wins over increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tens <= 4'd0;
            r_ones <= 4'd0;
            r_bin  <= 7'd0;
        end else if (i_clr) begin
            r_tens <= 4'd0;
            r_ones <= 4'd0;
            r_bin  <= 7'd0;
        end else if (i_inc) begin
            r_bin <= r_bin + 7'd1;
            if (r_ones == 4'd9) begin
                r_ones <= 4'd0;
                r_tens <= (r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1;
            end else begin
                r_ones <= r_ones + 4'd1;
            end
        end
    end

    assign o_bcd = {r_tens, r_ones};
    assign o_bin = r_bin;

endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong game-flow FSM: start, serve pause, scoring, game over
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 7,
    parameter int PAUSE_CYCLES = 200000000,
    parameter int CNT_W        = 28
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic       miss,
    input  logic [1:0] hit,
    output logic       gra_still,
    output logic [7:0] p1_score,
    output logic [7:0] p2_score,
    output logic [1:0] winner,
    output logic       game_over,
    output logic [1:0] state_o
);

    localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_CYCLES - 1);
    localparam logic [6:0]       WIN_BIN    = 7'(WIN_SCORE);

    state_t           r_state;
    logic             r_gra_still;
    logic [1:0]       r_winner;
    logic             r_game_over;
    logic [CNT_W-1:0] r_cnt;
    logic             r_btn_any;
    logic             r_armed;

    logic [6:0] w_p1_bin;
    logic [6:0] w_p2_bin;
    logic       w_start;
    logic       w_p1_inc;
    logic       w_p2_inc;
    logic       w_pause_done;
    logic       w_clr;

    // The edge register is still 0 on the first clock after reset, so a button
    // held through reset would look like a fresh press; r_armed masks that clock.
    assign w_start      = (|btn) & ~r_btn_any & r_armed;
    assign w_p1_inc     = (r_state == S_PLAY) && miss && (hit == HIT_RIGHT);
    assign w_p2_inc     = (r_state == S_PLAY) && miss && (hit == HIT_LEFT);
    assign w_pause_done = (r_cnt == PAUSE_LAST);
    assign w_clr        = (r_state == S_OVER) && w_pause_done;

    bcd2_counter u_p1 (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_clr),
        .i_inc (w_p1_inc),
        .o_bcd (p1_score),
        .o_bin (w_p1_bin)
    );

    bcd2_counter u_p2 (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_clr),
        .i_inc (w_p2_inc),
        .o_bcd (p2_score),
        .o_bin (w_p2_bin)
    );

    // Game-flow FSM with registered ball-freeze, winner and game-over outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_NEWGAME;
            r_gra_still <= 1'b1;
            r_winner    <= WIN_NONE;
            r_game_over <= 1'b0;
            r_cnt       <= '0;
            r_btn_any   <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_btn_any <= |btn;
            r_armed   <= 1'b1;
            case (r_state)
                S_NEWGAME: begin
                    r_gra_still <= 1'b1;
                    r_winner    <= WIN_NONE;
                    if (w_start) begin
                        r_state     <= S_PLAY;
                        r_gra_still <= 1'b0;
                    end
                end
                S_PLAY: begin
                    r_gra_still <= 1'b0;
                    r_cnt       <= '0;
                    if (w_p1_inc || w_p2_inc) begin
                        r_gra_still <= 1'b1;
                        if (w_p1_inc && (w_p1_bin + 7'd1 == WIN_BIN)) begin
                            r_state     <= S_OVER;
                            r_winner    <= WIN_P1;
                            r_game_over <= 1'b1;
                        end else if (w_p2_inc && (w_p2_bin + 7'd1 == WIN_BIN)) begin
                            r_state     <= S_OVER;
                            r_winner    <= WIN_P2;
                            r_game_over <= 1'b1;
                        end else begin
                            r_state <= S_NEWBALL;
                        end
                    end
                end
                S_NEWBALL: begin
                    r_gra_still <= 1'b1;
                    r_cnt       <= r_cnt + 1'b1;
                    if (w_pause_done) begin
                        r_state     <= S_PLAY;
                        r_gra_still <= 1'b0;
                        r_cnt       <= '0;
                    end
                end
                S_OVER: begin
                    r_gra_still <= 1'b1;
                    r_cnt       <= r_cnt + 1'b1;
                    if (w_pause_done) begin
                        r_state     <= S_NEWGAME;
                        r_winner    <= WIN_NONE;
                        r_game_over <= 1'b0;
                        r_cnt       <= '0;
                    end
                end
                default: r_state <= S_NEWGAME;
            endcase
        end
    end

    assign gra_still = r_gra_still;
    assign winner    = r_winner;
    assign game_over = r_game_over;
    assign state_o   = r_state;

endmodule
